pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined add/subtract unit; the registered, flow-controlled successor to the team's combinational 32-bit full adder. Splits a WIDTH-bit operation into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages. Accepts one operation per cycle over a valid/ready handshake and reports carry-out and signed overflow. Sits between an operand source and a result consumer that may apply backpressure.

## Interface
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline depth and chunk count; range 1..WIDTH; chunk width CW = WIDTH/STAGES.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset: synchronous, active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  unit can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used for add only.
- sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b; cin ignored).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow, a >= b unsigned).
- ovf  output  1  signed two's-complement overflow.

## Operation
- Accept: in_valid && in_ready at rising edge; a, b, cin, sub captured that edge. in_valid ignored while rst high.
- Sub is a + ~b + 1: operand B inverted, chunk-0 carry-in forced to 1.
- Stage k (0..STAGES-1) adds bits [k*CW +: CW] of A and effective B plus the carry registered by stage k-1; higher chunks of operands and lower chunks of result travel with the transaction in skew registers.
- Each stage has a valid bit; bubbles propagate as invalid slots.
- Stall = out_valid && !out_ready. On stall every stage, including the output register, holds; in_ready = !stall (combinational). Without stall all stages advance each cycle.
- ovf = carry into MSB XOR carry out of MSB, computed in final stage.
- Widths: internal chunk sums are CW+1 bits; no other width extension. Result wraps modulo 2^WIDTH unless saturation is compiled in.
- WIDTH % STAGES != 0 or STAGES < 1: elaboration-time error.

## Timing
- Reset: all valid bits 0; out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 once rst low (combinational from out_valid).
- Latency: operation accepted at edge N has out_valid=1 after edge N+STAGES, absent stall. STAGES=1 gives one registered adder.
- Throughput: 1 op/cycle with out_ready held high.
- Output held stable (sum, cout, ovf, out_valid) while out_valid && !out_ready.
- Simultaneous accept and output consume in a non-stalled cycle: both happen, no bubble inserted.
- Stall with bubbles in pipe: pipe still holds entirely (no bubble collapsing).
- Reset mid-operation: all in-flight operations discarded; out_valid=0 after the reset edge.

## Configuration
- PIPELINED_ADDER_SAT_EN defined: on ovf=1, sum clamps to signed extreme — 0x7F..F when sign of true result is positive (MSB carry-out 0), 0x80..0 when negative; cout and ovf still reported unmodified.
- Not defined: sum wraps modulo 2^WIDTH; no clamp logic generated.

## Structure
- Shared package pipelined_adder_pkg: op encoding constants OP_ADD=0, OP_SUB=1; function computing CW and parameter-legality check.
- One sub-module adder_stage: CW-bit adder with registered sum chunk, registered carry, and valid bit, with hold input; instantiated STAGES times via generate. Top level holds skew registers, ovf/saturation, handshake.

## Test plan
- Reset: rst high 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 after release; nothing emerges 4+ cycles later.
- Carry ripple (WIDTH=32, STAGES=4): add 0xFFFFFFFF+0x00000001, cin=0 -> after 4 edges sum=0x00000000, cout=1, ovf=0; 0x0000FFFF+0x0000FFFF cin=1 -> 0x0001FFFF, cout=0.
- Signed overflow: add 0x7FFFFFFF+0x00000001 -> ovf=1, cout=0, sum=0x80000000 (0x7FFFFFFF with PIPELINED_ADDER_SAT_EN).
- Subtract: 5-7 -> 0xFFFFFFFE, cout=0, ovf=0; 0x80000000-1 -> ovf=1, cout=1, sum=0x7FFFFFFF (0x80000000 with SAT_EN); cin=1 ignored.
- Backpressure: 8 back-to-back random ops, out_ready low 3 cycles mid-stream -> in_ready low same cycles, output held stable, all 8 results match reference model in order, none lost or duplicated.
- Reset mid-stream: 3 ops in flight, rst one cycle -> out_valid=0 next cycle; next accepted op emerges exactly 4 edges after acceptance.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encoding,
// chunk-width derivation and parameter legality.
package pipelined_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One chunk of the pipelined adder: CW-bit add with registered sum chunk,
// carry-out, carry into the chunk MSB, and a valid bit; everything holds on hold.
module adder_stage #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          vld_in,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic          vld,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    logic [CW:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
        end else if (!hold) begin
            vld <= vld_in;
        end
    end

    // Carry into the chunk MSB is recovered from the MSB sum bit; only the
    // last stage's copy feeds the overflow flag.
    always_ff @(posedge clk) begin
        if (!hold) begin
            sum  <= total[CW-1:0];
            cout <= total[CW];
            cmsb <= a[CW-1] ^ b[CW-1] ^ total[CW-1];
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with valid/ready flow control, carry-out and
// signed overflow. Define PIPELINED_ADDER_SAT_EN to clamp overflowing results.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    generate
        if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be divisible by STAGES and 1 <= STAGES <= WIDTH");
        end
    endgenerate

    logic stall;

    // Operand capture register: B already inverted and chunk-0 carry forced for subtract.
    logic             vld_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             c_p0;

    logic [WIDTH-1:0] src_a    [STAGES];
    logic [WIDTH-1:0] src_b    [STAGES];
    logic [WIDTH-1:0] src_r    [STAGES];
    logic             src_c    [STAGES];
    logic             src_v    [STAGES];
    logic [WIDTH-1:0] a_skew_p [STAGES];
    logic [WIDTH-1:0] b_skew_p [STAGES];
    logic [WIDTH-1:0] res_p    [STAGES];
    logic [WIDTH-1:0] merged   [STAGES];
    logic             stg_vld  [STAGES];
    logic [CW-1:0]    stg_sum  [STAGES];
    logic             stg_cout [STAGES];
    logic             stg_cmsb [STAGES];

    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_res;
    logic             ovf_raw;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (!stall) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            a_p0 <= a;
            b_p0 <= (sub == OP_SUB) ? ~b : b;
            c_p0 <= (sub == OP_SUB) ? 1'b1 : cin;
        end
    end

    // Stage k consumes what stage k-1 produced; merged[k] is the result so far
    // with chunk k filled in from the stage register.
    always_comb begin
        src_a[0] = a_p0;
        src_b[0] = b_p0;
        src_c[0] = c_p0;
        src_v[0] = vld_p0;
        src_r[0] = '0;
        for (int k = 0; k < STAGES; k++) begin
            merged[k] = res_p[k];
            merged[k][k*CW +: CW] = stg_sum[k];
        end
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_skew_p[k-1];
            src_b[k] = b_skew_p[k-1];
            src_c[k] = stg_cout[k-1];
            src_v[k] = stg_vld[k-1];
            src_r[k] = merged[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_skew_p[k] <= src_a[k];
                b_skew_p[k] <= src_b[k];
                res_p[k]    <= src_r[k];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            adder_stage #(
                .CW(CW)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .hold   (stall),
                .vld_in (src_v[g]),
                .a      (src_a[g][g*CW +: CW]),
                .b      (src_b[g][g*CW +: CW]),
                .cin    (src_c[g]),
                .vld    (stg_vld[g]),
                .sum    (stg_sum[g]),
                .cout   (stg_cout[g]),
                .cmsb   (stg_cmsb[g])
            );
        end
    endgenerate

    // Final stage boundary: flags and optional clamp from the last stage registers.
    assign sum_raw = merged[STAGES-1];
    assign ovf_raw = stg_cout[STAGES-1] ^ stg_cmsb[STAGES-1];

`ifdef PIPELINED_ADDER_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic of, input logic co);
        if (!of) begin
            return raw;
        end
        return co ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign sum_res = saturate(sum_raw, ovf_raw, stg_cout[STAGES-1]);
`else
    assign sum_res = sum_raw;
`endif

    // Data registers are not reset, so outputs read zero whenever no result is present.
    assign out_valid = stg_vld[STAGES-1];
    assign sum       = out_valid ? sum_res : '0;
    assign cout      = out_valid && stg_cout[STAGES-1];
    assign ovf       = out_valid && ovf_raw;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4) against an
// arithmetic reference model; honours PIPELINED_ADDER_SAT_EN when defined.
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks;
    int failures;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    pipelined_adder #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic s);
        longint ux, uy, ures, sx, sy, sres, c;
        res_t r;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        c  = ci ? 64'sd1 : 64'sd0;
        if (s) begin
            ures   = ux - uy;
            sres   = sx - sy;
            r.cout = (ux >= uy);
        end else begin
            ures   = ux + uy + c;
            sres   = sx + sy + c;
            r.cout = (ures > 64'sd4294967295);
        end
        r.sum = ures[31:0];
        r.ovf = (sres > SMAX) || (sres < SMIN);
`ifdef PIPELINED_ADDER_SAT_EN
        if (r.ovf) r.sum = (sres > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        return r;
    endfunction

    task automatic single_op(input string name, input logic [31:0] x, input logic [31:0] y,
                             input logic ci, input logic s);
        res_t exp;
        int   n;
        exp = model(x, y, ci, s);
        @(posedge clk); #1;
        out_ready = 1'b1;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'(($urandom)); sub = 1'(($urandom));
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 20);
        checks++;
        if (n != STAGES || out_valid !== 1'b1)
            begin failures++; $display("FAIL %s latency: got %0d edges (out_valid=%b), need %0d", name, n, out_valid, STAGES); end
        checks++;
        if (sum !== exp.sum)
            begin failures++; $display("FAIL %s sum: got %h need %h", name, sum, exp.sum); end
        checks++;
        if (cout !== exp.cout)
            begin failures++; $display("FAIL %s cout: got %b need %b", name, cout, exp.cout); end
        checks++;
        if (ovf !== exp.ovf)
            begin failures++; $display("FAIL %s ovf: got %b need %b", name, ovf, exp.ovf); end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid: got %b need 0", out_valid); end
        checks++;
        if (sum !== '0) begin failures++; $display("FAIL reset sum: got %h need 0", sum); end
        checks++;
        if (cout !== 1'b0) begin failures++; $display("FAIL reset cout: got %b need 0", cout); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset ovf: got %b need 0", ovf); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready: got %b need 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL reset ghost cycle %0d: out_valid=%b need 0", i, out_valid); end
        end
    endtask

    task automatic test_carry_ripple();
        single_op("carry_all_ones", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        single_op("carry_cin",      32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        single_op("ovf_pos",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        single_op("ovf_neg",  32'h80000000, 32'h80000000, 1'b0, 1'b0);
    endtask

    task automatic test_subtract();
        single_op("sub_borrow",    32'd5,        32'd7,        1'b0, 1'b1);
        single_op("sub_ovf",       32'h80000000, 32'h00000001, 1'b0, 1'b1);
        single_op("sub_cin_ign",   32'd5,        32'd7,        1'b1, 1'b1);
        single_op("sub_equal",     32'h12345678, 32'h12345678, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            single_op("random", $urandom, $urandom, 1'(($urandom)), 1'(($urandom)));
    endtask

    task automatic test_backpressure();
        res_t q[$];
        res_t exp;
        res_t held;
        int   sent, got, cyc;
        bit   was_stall;
        sent = 0; got = 0; cyc = 0; was_stall = 0;
        held = '0;
        while (got < 8 && cyc < 60) begin
            @(posedge clk); #1;
            if (was_stall) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== held.sum || cout !== held.cout || ovf !== held.ovf)
                    begin failures++; $display("FAIL bp_hold: got v=%b %h/%b/%b need v=1 %h/%b/%b", out_valid, sum, cout, ovf, held.sum, held.cout, held.ovf); end
            end
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                a = $urandom; b = $urandom; cin = 1'(($urandom)); sub = 1'(($urandom));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0)
                    begin failures++; $display("FAIL bp_stall cyc %0d: out_valid=%b in_ready=%b need 1/0", cyc, out_valid, in_ready); end
            end else begin
                checks++;
                if (in_ready !== 1'b1)
                    begin failures++; $display("FAIL bp_ready cyc %0d: in_ready=%b need 1", cyc, in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL bp_extra: result %h with nothing outstanding", sum);
                end else begin
                    exp = q.pop_front();
                    if (sum !== exp.sum || cout !== exp.cout || ovf !== exp.ovf)
                        begin failures++; $display("FAIL bp_result %0d: got %h/%b/%b need %h/%b/%b", got, sum, cout, ovf, exp.sum, exp.cout, exp.ovf); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
            end
            was_stall = out_valid && !out_ready;
            held.sum = sum; held.cout = cout; held.ovf = ovf;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (sent != 8 || got != 8)
            begin failures++; $display("FAIL bp_count: sent=%0d got=%0d need 8/8", sent, got); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_dup: out_valid=%b need 0 after drain", out_valid); end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0)
            begin failures++; $display("FAIL midrst_flush: out_valid=%b sum=%h need 0/0", out_valid, sum); end
        single_op("midrst_next", $urandom, $urandom, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_carry_ripple();
        test_overflow();
        test_subtract();
        test_random();
        test_backpressure();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
